// File: rtl/bcd_down_timer.sv
// Three-digit BCD countdown timer with start/pause/load control and
// direct active-low 7-segment drive for the DE-board HEX displays.
module bcd_down_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int TICK_W   = 26
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        load,
    input  logic [11:0] load_value,
    input  logic        start,
    input  logic        pause,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX0,
    output logic        running,
    output logic        done,
    output logic        tick
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    localparam logic [TICK_W-1:0] PRESC_LAST = TICK_W'(TICK_DIV - 1);

    state_t            state_q, state_d;
    logic [TICK_W-1:0] presc_q, presc_d;
    logic [3:0]        d2_q, d2_d;
    logic [3:0]        d1_q, d1_d;
    logic [3:0]        d0_q, d0_d;
    logic              running_q;
    logic              done_q;
    logic              tick_q, tick_d;

    logic [3:0]        dec2, dec1, dec0;
    logic              at_wrap;
    logic              count_zero;
    logic              dec_zero;

    function automatic logic [3:0] clamp9(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    // Segment order {g,f,e,d,c,b,a}, active low
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // BCD decrement with borrow ripple; never evaluated at 000 in RUN
    always_comb begin
        dec2 = d2_q;
        dec1 = d1_q;
        dec0 = d0_q - 4'd1;
        if (d0_q == 4'd0) begin
            dec0 = 4'd9;
            if (d1_q == 4'd0) begin
                dec1 = 4'd9;
                dec2 = d2_q - 4'd1;
            end else begin
                dec1 = d1_q - 4'd1;
            end
        end
    end

    assign at_wrap    = (presc_q == PRESC_LAST);
    assign count_zero = ({d2_q, d1_q, d0_q} == 12'h000);
    assign dec_zero   = ({dec2, dec1, dec0} == 12'h000);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        d2_d    = d2_q;
        d1_d    = d1_q;
        d0_d    = d0_q;
        tick_d  = 1'b0;
        if (load) begin
            d2_d    = clamp9(load_value[11:8]);
            d1_d    = clamp9(load_value[7:4]);
            d0_d    = clamp9(load_value[3:0]);
            presc_d = '0;
            state_d = S_IDLE;
        end else if (pause) begin
            if (state_q == S_RUN) begin
                state_d = S_PAUSED;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = count_zero ? S_DONE : S_RUN;
                    end
                end
                S_PAUSED: begin
                    if (start) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (at_wrap) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        d2_d    = dec2;
                        d1_d    = dec1;
                        d0_d    = dec0;
                        if (dec_zero) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        presc_d = presc_q + TICK_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            d2_q      <= 4'd0;
            d1_q      <= 4'd0;
            d0_q      <= 4'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            d2_q      <= d2_d;
            d1_q      <= d1_d;
            d0_q      <= d0_d;
            running_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_DONE);
            tick_q    <= tick_d;
        end
    end

    assign digit2  = d2_q;
    assign digit1  = d1_q;
    assign digit0  = d0_q;
    assign HEX2    = seg7(d2_q);
    assign HEX1    = seg7(d1_q);
    assign HEX0    = seg7(d0_q);
    assign running = running_q;
    assign done    = done_q;
    assign tick    = tick_q;

endmodule

// File: doc/bcd_down_timer.md
# bcd_down_timer

Three-digit BCD countdown timer with a start/pause/load control FSM, for the 7-segment display path on the DE-board designs. A prescaler divides the 50 MHz clock to one tick per TICK_DIV cycles. Each tick decrements a 000–999 BCD count. The block stops at 000 and raises `done`. It drives three active-low HEX digits directly and exposes the BCD digits for downstream logic.

## Interface
- `TICK_DIV`, default 50000000: clock cycles per count decrement; legal range is ≥ 2.
- `TICK_W`, default 26: prescaler width; must satisfy 2^TICK_W ≥ TICK_DIV.
- `CLOCK_50`, input, 1 bit: the single clock; all state changes on its rising edge.
- `reset`, input, 1 bit: asynchronous, active-high reset.
- `load`, input, 1 bit: synchronous; when high, captures `load_value`.
- `load_value`, input, 12 bits: BCD digits {hundreds[11:8], tens[7:4], ones[3:0]}.
- `start`, input, 1 bit: level-sampled each cycle; begins or resumes counting.
- `pause`, input, 1 bit: level-sampled each cycle; suspends counting.
- `digit2`, `digit1`, `digit0`, output, 4 bits each: current count (hundreds, tens, ones).
- `HEX2`, `HEX1`, `HEX0`, output, 7 bits each: active-low segments {g,f,e,d,c,b,a} for `digit2`..`digit0`.
- `running`, output, 1 bit: high in state RUN.
- `done`, output, 1 bit: high in state DONE.
- `tick`, output, 1 bit: one-cycle pulse on every decrement edge.

## Operation
- FSM states:
  - IDLE: loaded, not counting.
  - RUN: counting.
  - PAUSED: frozen mid-count.
  - DONE: reached 000.
- Reset values: state IDLE, all digits 0, prescaler 0, `running`=0, `done`=0, `tick`=0, HEX outputs 7'b1000000 ("0").
- Input priority each cycle: `load` > `pause` > `start`.
- `load`:
  - Accepted in any state.
  - Loads digits from `load_value`; any nibble > 9 is clamped to 9.
  - Clears the prescaler and moves to IDLE, which clears `done`.
- `start` (with `load` and `pause` low):
  - From IDLE or PAUSED with count ≠ 000: go to RUN.
  - From IDLE with count = 000: go straight to DONE.
  - Ignored in RUN and DONE; leaving DONE requires `load`.
- `pause` (with `load` low): RUN → PAUSED. The prescaler holds its value, so resuming continues the partial period. `pause` is ignored in all other states.
- Prescaler:
  - Increments only in RUN.
  - At TICK_DIV−1 it wraps to 0 and a tick occurs.
- Tick behaviour:
  - Count decrements by one in BCD.
  - Ones 0 → 9 with borrow into tens; tens 0 → 9 with borrow into hundreds.
  - Example: 100 → 099, 010 → 009.
- Terminal condition: if the tick produces 000, the state moves to DONE on the same edge. The count holds at 000 and never wraps to 999.
- HEX encoding:
  - Purely combinational from the digits.
  - 0–9 use standard patterns: 0=1000000, 1=1111001, … 9=0010000.
  - After clamping, digits never exceed 9.

## Timing
- `load` sampled at edge N: digits, state and HEX reflect the new value after edge N; `done` is low after edge N.
- Counting latency: `start` sampled at edge N (entering RUN with prescaler 0) → first decrement at edge N+TICK_DIV, then every TICK_DIV edges.
- `tick` is registered: high for exactly the cycle following each decrement edge, aligned with the new digit values.
- `done` and `running` are registered state decodes. `done` rises in the same cycle that the digits first show 000.
- Full countdown from value V with no pauses: DONE is reached V×TICK_DIV cycles after the start edge.
- Pause edge sampled at N: no decrement at edge N even if the prescaler was at TICK_DIV−1, because pause has priority.
- Asynchronous `reset` mid-count: all outputs return to their reset values immediately, without waiting for a clock edge.
- `load` coincident with a tick edge: the load wins and no decrement is applied.

## Test plan
Use TICK_DIV=4 in simulation.
1. Reset while counting from 005 → digits 000, HEX0=1000000, `running`=0, `done`=0, and all of these hold asynchronously before the next edge.
2. Load 0x012 and start → digits step 012, 011, 010, 009, … 000 at 4-cycle spacing. `tick` pulses 12 times, and `done` rises with 000 exactly 48 cycles after the start edge.
3. Load 0x100 and start → the first tick shows 099; HEX2=1000000, HEX1=0010000, HEX0=0010000.
4. Load 0x003, start, pause 2 cycles in, hold pause 10 cycles, then start → the next decrement (003 → 002) comes 2 cycles after resume; total time to DONE is 12 running cycles.
5. Load 0xFA5 → digits 9, 9, 5. Start with 000 loaded → `done`=1 on the next edge with no ticks. Start in DONE leaves the state unchanged; `load` clears `done`.
6. Load and pause asserted on the same edge as a pending tick (prescaler=3) → the loaded value appears with no decrement and the state is IDLE.
